// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - Q5.10 sign-magnitude constants, conversion helper and accumulator FSM states
package nn_fixed_pkg;

  localparam int INT_W  = 5;
  localparam int FRAC_W = 10;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-2:0] SM_MAX_MAG = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    OUT   = 2'd3
  } acc_state_t;

  // Sign-magnitude word to a 17-bit two's-complement value; 16'h8000 maps to 0.
  function automatic logic signed [WORD_W:0] sm_to_tc(input logic [WORD_W-1:0] sm);
    logic signed [WORD_W:0] mag;
    mag = {2'b00, sm[WORD_W-2:0]};
    return sm[WORD_W-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/sm_saturate.sv
// rtl/sm_saturate.sv - two's-complement accumulator to saturated Q5.10 sign-magnitude with optional ReLU
module sm_saturate
  import nn_fixed_pkg::*;
#(
  parameter int ACC_WIDTH = 28,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [WORD_W-1:0]    result,
  output logic                        sat
);

  logic                 neg;
  logic [ACC_WIDTH-1:0] mag;

  assign neg = acc[ACC_WIDTH-1];

  // The accumulator is sized so it never holds its most negative value, so negation is exact.
  assign mag = neg ? $unsigned(-acc) : $unsigned(acc);

  // ReLU first, then clamp magnitudes above 15 bits; a negative value always has nonzero magnitude.
  always_comb begin
    result = '0;
    sat    = 1'b0;
    if (RELU_EN && neg) begin
      result = '0;
      sat    = 1'b0;
    end else if (|mag[ACC_WIDTH-1:WORD_W-1]) begin
      result = {neg, SM_MAX_MAG};
      sat    = 1'b1;
    end else begin
      result = {neg, mag[WORD_W-2:0]};
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums NUM_INPUTS Q5.10 products plus bias into one saturated activation
module neuron_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int ACC_WIDTH  = 28,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bias,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              busy,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              sat
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int EXT_W = ACC_WIDTH - WORD_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  acc_state_t                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic        [CNT_W-1:0]     count;
  logic        [WORD_W-1:0]    bias_reg;

  logic signed [WORD_W:0]      in_tc;
  logic signed [WORD_W:0]      bias_tc;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic        [WORD_W-1:0]    act;
  logic                        act_sat;

  assign in_tc    = sm_to_tc(in_data);
  assign bias_tc  = sm_to_tc(bias_reg);
  assign in_ext   = {{EXT_W{in_tc[WORD_W]}}, in_tc};
  assign bias_ext = {{EXT_W{bias_tc[WORD_W]}}, bias_tc};

  sm_saturate #(
    .ACC_WIDTH (ACC_WIDTH),
    .RELU_EN   (RELU_EN)
  ) u_sm_saturate (
    .acc    (acc),
    .result (act),
    .sat    (act_sat)
  );

  // Sequencer: start -> accumulate products -> add bias -> register the activation.
  // busy stays high through the out_valid cycle, so a start landing there is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      bias_reg  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          sat       <= 1'b0;
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            acc      <= '0;
            count    <= '0;
            bias_reg <= bias;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= acc + in_ext;
            count <= count + 1'b1;
            if (count == LAST_CNT) begin
              state <= BIAS;
            end
          end
        end
        BIAS: begin
          acc   <= acc + bias_ext;
          state <= OUT;
        end
        OUT: begin
          out_data  <= act;
          sat       <= act_sat;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed vector bench for neuron_accumulator with and without ReLU
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = 16'h0000;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;

  logic        busy_r, ov_r, sat_r;
  logic [15:0] od_r;
  logic        busy_l, ov_l, sat_l;
  logic [15:0] od_l;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0][15:0] ins;
    logic [15:0]      b;
    logic [15:0]      exp_r;
    logic             exp_sat_r;
    logic [15:0]      exp_l;
    logic             exp_sat_l;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  neuron_accumulator #(.NUM_INPUTS(4), .ACC_WIDTH(20), .RELU_EN(1'b1)) u_relu (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .busy      (busy_r),
    .out_valid (ov_r),
    .out_data  (od_r),
    .sat       (sat_r)
  );

  neuron_accumulator #(.NUM_INPUTS(4), .ACC_WIDTH(20), .RELU_EN(1'b0)) u_lin (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .busy      (busy_l),
    .out_valid (ov_l),
    .out_data  (od_l),
    .sat       (sat_l)
  );

  function automatic vec_t mk(input logic [15:0] i0, input logic [15:0] i1,
                              input logic [15:0] i2, input logic [15:0] i3,
                              input logic [15:0] b,
                              input logic [15:0] er, input logic sr,
                              input logic [15:0] el, input logic sl);
    vec_t v;
    v.ins[0] = i0; v.ins[1] = i1; v.ins[2] = i2; v.ins[3] = i3;
    v.b = b; v.exp_r = er; v.exp_sat_r = sr; v.exp_l = el; v.exp_sat_l = sl;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic with_valid, input logic [15:0] d);
    start    = 1'b1;
    bias     = b;
    in_valid = with_valid;
    in_data  = d;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Called 1ns after the last accepting edge t; out_valid must appear only after edge t+2.
  task automatic check_result(input string lbl, input logic [15:0] er, input logic sr,
                              input logic [15:0] el, input logic sl);
    check({lbl, "_ov_t0_r"}, {15'b0, ov_r}, 16'h0);
    check({lbl, "_ov_t0_l"}, {15'b0, ov_l}, 16'h0);
    tick();
    check({lbl, "_ov_t1_r"}, {15'b0, ov_r}, 16'h0);
    check({lbl, "_ov_t1_l"}, {15'b0, ov_l}, 16'h0);
    tick();
    check({lbl, "_ov_r"},   {15'b0, ov_r},   16'h1);
    check({lbl, "_ov_l"},   {15'b0, ov_l},   16'h1);
    check({lbl, "_busy_r"}, {15'b0, busy_r}, 16'h1);
    check({lbl, "_data_r"}, od_r, er);
    check({lbl, "_data_l"}, od_l, el);
    check({lbl, "_sat_r"},  {15'b0, sat_r},  {15'b0, sr});
    check({lbl, "_sat_l"},  {15'b0, sat_l},  {15'b0, sl});
    tick();
    check({lbl, "_ov_end_r"},   {15'b0, ov_r},   16'h0);
    check({lbl, "_busy_end_l"}, {15'b0, busy_l}, 16'h0);
    check({lbl, "_hold_r"}, od_r, er);
    check({lbl, "_hold_l"}, od_l, el);
  endtask

  initial begin
    vecs[0] = mk(16'h0400, 16'h0400, 16'h8200, 16'h0000, 16'h0100, 16'h0700, 1'b0, 16'h0700, 1'b0);
    vecs[1] = mk(16'h8400, 16'h8400, 16'h8400, 16'h8400, 16'h0000, 16'h0000, 1'b0, 16'h9000, 1'b0);
    vecs[2] = mk(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h0400, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    vecs[3] = mk(16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b1);
    vecs[4] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    vecs[5] = mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0);
    vecs[6] = mk(16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    vecs[7] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    vecs[8] = mk(16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h8800, 16'h0000, 1'b0, 16'h8400, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {15'b0, busy_r}, 16'h0);
    check("rst_ov",   {15'b0, ov_l},   16'h0);
    check("rst_data", od_r, 16'h0000);
    check("rst_sat",  {15'b0, sat_l},  16'h0);
    reset = 1'b0;
    tick();

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      do_start(vecs[v].b, 1'b0, 16'h0000);
      for (int k = 0; k < 4; k++) feed(vecs[v].ins[k]);
      check_result($sformatf("vec%0d", v), vecs[v].exp_r, vecs[v].exp_sat_r,
                   vecs[v].exp_l, vecs[v].exp_sat_l);
    end

    // Interference: stray in_valid in IDLE, start+in_valid together, restart in ACCUM,
    // in_valid during BIAS and during the result cycle.
    feed(16'h7C00);
    check("intf_idle_busy", {15'b0, busy_r}, 16'h0);
    do_start(16'h0100, 1'b1, 16'h7C00);
    feed(16'h0400);
    feed(16'h0400);
    check("intf_accum_busy", {15'b0, busy_l}, 16'h1);
    do_start(16'h4000, 1'b0, 16'h0000);
    feed(16'h0400);
    feed(16'h0400);
    in_valid = 1'b1;
    in_data  = 16'h7C00;
    check("intf_ov_t0", {15'b0, ov_r}, 16'h0);
    tick();
    check("intf_ov_t1", {15'b0, ov_r}, 16'h0);
    tick();
    in_valid = 1'b0;
    check("intf_ov",     {15'b0, ov_r}, 16'h1);
    check("intf_data_r", od_r, 16'h1100);
    check("intf_data_l", od_l, 16'h1100);
    check("intf_sat_l",  {15'b0, sat_l}, 16'h0);
    tick();
    check("intf_ov_end", {15'b0, ov_l},   16'h0);
    check("intf_busy_end", {15'b0, busy_r}, 16'h0);

    // Reset mid-accumulation
    do_start(16'h0000, 1'b0, 16'h0000);
    feed(16'h0400);
    feed(16'h0400);
    reset = 1'b1;
    #1;
    check("mrst_busy", {15'b0, busy_r}, 16'h0);
    check("mrst_data", od_l, 16'h0000);
    check("mrst_ov",   {15'b0, ov_r},   16'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mrst_quiet%0d", c), {15'b0, ov_r | ov_l}, 16'h0);
    end
    do_start(vecs[0].b, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) feed(vecs[0].ins[k]);
    check_result("post_rst", vecs[0].exp_r, vecs[0].exp_sat_r, vecs[0].exp_l, vecs[0].exp_sat_l);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
